// File: rtl/muu_resp_framer.sv
// Store-and-forward response framer: buffers complete response packets, then emits
// one TX descriptor followed by that packet's payload words.
module muu_resp_framer #(
  parameter int unsigned META_WIDTH          = 96,
  parameter int unsigned MAX_WORDS_IN_PACKET = 160,
  parameter int unsigned DATA_DEPTH          = 256,
  parameter int unsigned DESC_DEPTH          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [META_WIDTH+511:0]   in_data,
  input  logic [7:0]                in_user,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [39:0]               desc_data,
  output logic                      desc_valid,
  input  logic                      desc_ready,
  output logic [511:0]              out_data,
  output logic [63:0]               out_keep,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               stat_packets,
  output logic [15:0]               stat_forced
);

  localparam int unsigned PAY_W   = 512;
  localparam int unsigned DWORD_W = PAY_W + 1;
  localparam int unsigned DA_W    = $clog2(DATA_DEPTH);
  localparam int unsigned DC_W    = $clog2(DATA_DEPTH + 1);
  localparam int unsigned QA_W    = $clog2(DESC_DEPTH);
  localparam int unsigned QC_W    = $clog2(DESC_DEPTH + 1);
  localparam int unsigned WC_W    = $clog2(MAX_WORDS_IN_PACKET);

  typedef struct packed {
    logic [7:0]  user;
    logic [15:0] len;
    logic [15:0] sess;
  } desc_t;

  typedef enum logic [1:0] {O_IDLE, O_DESC, O_DATA} ostate_t;

  logic [DWORD_W-1:0] data_mem [DATA_DEPTH];
  logic [DA_W-1:0]    data_wr, data_rd;
  logic [DC_W-1:0]    data_cnt, data_cnt_n;
  desc_t              desc_mem [DESC_DEPTH];
  logic [QA_W-1:0]    desc_wr, desc_rd;
  logic [QC_W-1:0]    desc_cnt, desc_cnt_n;

  logic [WC_W-1:0]    wcnt;
  logic [15:0]        sess_q;
  logic [7:0]         user_q;
  logic               desc_push_q;
  desc_t              desc_word_q;

  ostate_t            ostate;
  logic               fetched_last;

  logic               in_fire_c, forced_c, close_c, data_pop_c, desc_pop_c, in_ready_n;
  logic [15:0]        in_sess_c;
  logic [7:0]         in_user_c;
  desc_t              desc_new_c;
  logic               unused_meta;

  assign out_keep = '1;

  // Handshakes, close detection and next-state FIFO levels
  always_comb begin
    in_fire_c  = in_valid && in_ready;
    forced_c   = (32'(wcnt) + 32'd1 == MAX_WORDS_IN_PACKET);
    close_c    = in_fire_c && (in_last || forced_c);
    in_sess_c  = (wcnt == '0) ? in_data[PAY_W +: 16] : sess_q;
    in_user_c  = (wcnt == '0) ? in_user : user_q;
    desc_new_c = '{user: in_user_c,
                   len:  16'((32'(wcnt) + 32'd1) * 32'd64),
                   sess: in_sess_c};
    desc_pop_c = (ostate == O_DESC) && desc_valid && desc_ready;
    data_pop_c = (ostate == O_DATA) && !fetched_last && (data_cnt != '0) &&
                 (!out_valid || out_ready);
    data_cnt_n = data_cnt + DC_W'(in_fire_c) - DC_W'(data_pop_c);
    desc_cnt_n = desc_cnt + QC_W'(desc_push_q) - QC_W'(desc_pop_c);
    // A descriptor being closed this cycle is still in flight, so reserve its slot
    in_ready_n = (32'(data_cnt_n) < DATA_DEPTH) &&
                 (32'(desc_cnt_n) + 32'(close_c) < DESC_DEPTH);
    unused_meta = ^in_data[META_WIDTH+PAY_W-1:PAY_W+16];
  end

  // FIFO storage arrays (no reset; validity tracked by pointers/levels)
  always_ff @(posedge clk) begin
    if (in_fire_c) data_mem[data_wr] <= {in_data[PAY_W-1:0], in_last || forced_c};
    if (desc_push_q) desc_mem[desc_wr] <= desc_word_q;
  end

  // Input side: word counting, packet framing, descriptor generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      data_wr     <= '0;
      data_cnt    <= '0;
      desc_wr     <= '0;
      desc_cnt    <= '0;
      wcnt        <= '0;
      sess_q      <= '0;
      user_q      <= '0;
      desc_push_q <= 1'b0;
      desc_word_q <= '0;
      stat_forced <= '0;
    end else begin
      in_ready    <= in_ready_n;
      data_cnt    <= data_cnt_n;
      desc_cnt    <= desc_cnt_n;
      desc_push_q <= close_c;
      if (close_c) desc_word_q <= desc_new_c;
      if (desc_push_q) desc_wr <= desc_wr + QA_W'(1);
      if (in_fire_c) begin
        data_wr <= data_wr + DA_W'(1);
        if (wcnt == '0) begin
          sess_q <= in_data[PAY_W +: 16];
          user_q <= in_user;
        end
        wcnt <= close_c ? '0 : wcnt + WC_W'(1);
        if (close_c && !in_last && (stat_forced != '1))
          stat_forced <= stat_forced + 16'd1;
      end
    end
  end

  // Output FSM: descriptor first, then that packet's words through a 1-word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ostate       <= O_IDLE;
      desc_data    <= '0;
      desc_valid   <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_valid    <= 1'b0;
      fetched_last <= 1'b0;
      data_rd      <= '0;
      desc_rd      <= '0;
      stat_packets <= '0;
    end else begin
      case (ostate)
        O_IDLE: begin
          if (desc_cnt != '0) begin
            desc_data  <= desc_mem[desc_rd];
            desc_valid <= 1'b1;
            ostate     <= O_DESC;
          end
        end
        O_DESC: begin
          if (desc_pop_c) begin
            desc_valid   <= 1'b0;
            desc_rd      <= desc_rd + QA_W'(1);
            fetched_last <= 1'b0;
            ostate       <= O_DATA;
          end
        end
        O_DATA: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last     <= 1'b0;
              stat_packets <= stat_packets + 32'd1;
              ostate       <= O_IDLE;
            end
          end
          if (data_pop_c) begin
            out_data  <= data_mem[data_rd][DWORD_W-1:1];
            out_last  <= data_mem[data_rd][0];
            out_valid <= 1'b1;
            data_rd   <= data_rd + DA_W'(1);
            if (data_mem[data_rd][0]) fetched_last <= 1'b1;
          end
        end
        default: ostate <= O_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muu_resp_framer.sv
// Scoreboard bench for muu_resp_framer: directed packets, queued expectations, negedge monitor.
module tb_muu_resp_framer;

  localparam int unsigned MW  = 96;
  localparam int unsigned MAXW = 160;

  logic           clk;
  logic           rst_n;
  logic [MW+511:0] in_data;
  logic [7:0]     in_user;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [39:0]    desc_data;
  logic           desc_valid;
  logic           desc_ready;
  logic [511:0]   out_data;
  logic [63:0]    out_keep;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    stat_packets;
  logic [15:0]    stat_forced;

  muu_resp_framer dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_user(in_user), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .desc_data(desc_data), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .stat_packets(stat_packets), .stat_forced(stat_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [39:0]  exp_desc [$];
  logic [512:0] exp_data [$];
  int checks, errors;
  int pkt_model, forced_model;
  logic desc_hold, toggle_mode, stall_chk, saw_stall_out, track_full, saw_full;

  function automatic logic [511:0] pay(input int unsigned s);
    logic [511:0] p;
    for (int k = 0; k < 16; k++) p[k*32 +: 32] = (s * 32'd16 + 32'(k)) ^ 32'hA5A5_0000;
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive_word(input logic [15:0] sess, input int unsigned seed,
                            input logic [7:0] user, input logic last);
    int n;
    in_data  = {80'(seed), sess, pay(seed)};
    in_user  = user;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout got=0 exp=1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input int unsigned nwords, input logic [15:0] sess,
                          input logic [7:0] user, input int unsigned seed);
    int unsigned chunk;
    logic        last, close;
    chunk = 0;
    for (int unsigned i = 0; i < nwords; i++) begin
      last  = (i == nwords - 1);
      close = last || (chunk + 1 == MAXW);
      chunk++;
      exp_data.push_back({pay(seed + i), close});
      if (close) begin
        exp_desc.push_back({user, 16'(chunk * 64), sess});
        pkt_model++;
        if (!last) forced_model++;
        chunk = 0;
      end
      drive_word(sess, seed + i, user, last);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_desc.size() != 0 || exp_data.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_desc.size() + exp_data.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0]  ed;
    logic [512:0] ew;
    checks = 0; errors = 0; pkt_model = 0; forced_model = 0;
    desc_hold = 1'b0; toggle_mode = 1'b0; stall_chk = 1'b0; saw_stall_out = 1'b0;
    track_full = 1'b0; saw_full = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_user = '0; in_data = '0;
    desc_ready = 1'b1; out_ready = 1'b1;

    fork
      // Ready generator
      forever begin
        @(posedge clk);
        #1;
        desc_ready = !desc_hold;
        out_ready  = toggle_mode ? !out_ready : 1'b1;
      end
      // Monitor/scoreboard
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (desc_valid && desc_ready) begin
            checks++;
            if (exp_desc.size() == 0) begin
              errors++;
              $display("FAIL desc_unexpected got=%h exp=none", desc_data);
            end else begin
              ed = exp_desc.pop_front();
              if (desc_data !== ed) begin
                errors++;
                $display("FAIL desc got=%h exp=%h", desc_data, ed);
              end
            end
          end
          if (out_valid && out_ready) begin
            checks++;
            if (exp_data.size() == 0) begin
              errors++;
              $display("FAIL data_unexpected got_last=%b exp=none", out_last);
            end else begin
              ew = exp_data.pop_front();
              if ({out_data, out_last} !== ew || out_keep !== '1) begin
                errors++;
                $display("FAIL data got=%h last=%b keep=%h exp=%h last=%b",
                         out_data[63:0], out_last, out_keep, ew[64:1], ew[0]);
              end
            end
          end
          if (stall_chk && out_valid) saw_stall_out = 1'b1;
          if (track_full && !in_ready) saw_full = 1'b1;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_valids", 64'({desc_valid, out_valid, out_last}), 64'd0);
    chk("rst_keep", out_keep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_stats", 64'({stat_packets, stat_forced}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single-word packet
    send_pkt(1, 16'h0042, 8'h03, 100);
    wait_drain();
    chk("t1_stat_packets", 64'(stat_packets), 64'd1);

    // Three-word response
    send_pkt(3, 16'h1234, 8'h07, 200);
    wait_drain();
    chk("t2_stat_packets", 64'(stat_packets), 64'd2);

    // 200-word stream, forced close at 160
    send_pkt(200, 16'h0BEE, 8'h11, 1000);
    wait_drain();
    chk("t3_stat_forced", 64'(stat_forced), 64'd1);
    chk("t3_stat_packets", 64'(stat_packets), 64'd4);

    // Descriptor stall while 4 packets arrive
    desc_hold = 1'b1;
    stall_chk = 1'b1;
    send_pkt(2, 16'h0A01, 8'h21, 3000);
    send_pkt(5, 16'h0A02, 8'h22, 3100);
    send_pkt(1, 16'h0A03, 8'h23, 3200);
    send_pkt(3, 16'h0A04, 8'h24, 3300);
    repeat (39) @(posedge clk);
    #1;
    chk("t4_desc_valid_held", 64'(desc_valid), 64'd1);
    chk("t4_no_out_during_stall", 64'(saw_stall_out), 64'd0);
    stall_chk = 1'b0;
    desc_hold = 1'b0;
    wait_drain();
    chk("t4_stat_packets", 64'(stat_packets), 64'd8);

    // Toggled out_ready with back-to-back 8-word packets
    toggle_mode = 1'b1;
    track_full  = 1'b1;
    for (int p = 0; p < 60; p++) send_pkt(8, 16'(16'h5000 + p), 8'(p), 5000 + p * 8);
    track_full = 1'b0;
    wait_drain();
    toggle_mode = 1'b0;
    chk("t5_in_ready_dropped", 64'(saw_full), 64'd1);
    chk("t5_stat_packets", 64'(stat_packets), 64'd68);

    // Reset in the middle of a 10-word packet
    for (int unsigned i = 0; i < 5; i++) drive_word(16'h7777, 9000 + i, 8'h77, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_valids", 64'({desc_valid, out_valid, out_last}), 64'd0);
    chk("t6_rst_desc_data", 64'(desc_data), 64'd0);
    chk("t6_rst_out_data", 64'(out_data[63:0]), 64'd0);
    chk("t6_rst_keep", out_keep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_rst_stats", 64'({stat_packets, stat_forced}), 64'd0);
    pkt_model = 0;
    forced_model = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(3, 16'h0099, 8'h09, 9500);
    wait_drain();
    chk("t6_stat_packets", 64'(stat_packets), 64'(pkt_model));
    chk("t6_stat_forced", 64'(stat_forced), 64'(forced_model));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
